// File: rtl/matmult_s_axi_regs.sv
// rtl/matmult_s_axi_regs.sv - AXI4-Lite slave holding the four matmult control registers
// Independent write (AW/W/B) and read (AR/R) FSMs; register contents and write pulses go to the core.
module matmult_s_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      reg_wr_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic          ready_en;
  logic [1:0]    aw_idx_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic [DW-1:0] regs [4];
  logic [3:0]    reg_wr_q;
  logic [DW-1:0] rdata_q;

  logic          awready, wready, bvalid, arready, rvalid;
  logic          aw_hs, w_hs, ar_hs, commit;
  logic [1:0]    c_idx;
  logic [DW-1:0] c_data;
  logic [SW-1:0] c_strb;

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies come only from state and the post-reset enable flop, never from VALID inputs.
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state)
      WR_IDLE:    begin awready = ready_en; wready = ready_en; end
      WR_HAVE_AW: wready  = 1'b1;
      WR_HAVE_W:  awready = 1'b1;
      WR_RESP:    bvalid  = 1'b1;
      default:    bvalid  = 1'b0;
    endcase
    aw_hs  = S_AXI_AWVALID & awready;
    w_hs   = S_AXI_WVALID & wready;
    c_idx  = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx_q;
    c_data = w_hs ? S_AXI_WDATA : wdata_q;
    c_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
    commit  = 1'b0;
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end else if (aw_hs) begin
          wr_next = WR_HAVE_AW;
        end else if (w_hs) begin
          wr_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: if (w_hs) begin commit = 1'b1; wr_next = WR_RESP; end
      WR_HAVE_W:  if (aw_hs) begin commit = 1'b1; wr_next = WR_RESP; end
      WR_RESP:    if (S_AXI_BREADY) wr_next = WR_IDLE;
      default:    wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    arready = (rd_state == RD_IDLE) & ready_en;
    rvalid  = (rd_state == RD_DATA);
    ar_hs   = S_AXI_ARVALID & arready;
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (S_AXI_RREADY) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
      ready_en <= 1'b0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      reg_wr_q <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      reg_wr_q <= '0;
      if (commit) begin
        for (int k = 0; k < SW; k++) begin
          if (c_strb[k]) regs[c_idx][8*k +: 8] <= c_data[8*k +: 8];
        end
        reg_wr_q[c_idx] <= 1'b1;
      end
      // Nonblocking sample means a read colliding with a commit returns the old value.
      if (ar_hs) rdata_q <= regs[S_AXI_ARADDR[3:2]];
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign reg0_o        = regs[0];
  assign reg1_o        = regs[1];
  assign reg2_o        = regs[2];
  assign reg3_o        = regs[3];
  assign reg_wr_o      = reg_wr_q;

endmodule

// File: tb/tb_matmult_s_axi_regs.sv
// tb/tb_matmult_s_axi_regs.sv - bench for matmult_s_axi_regs
// Cycle model of the register bank, per-cycle compare, directed cases then random traffic.
module tb_matmult_s_axi_regs;

  logic        clk;
  logic        aresetn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  reg_wr;

  matmult_s_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3), .reg_wr_o(reg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  bit chk_on;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: at most one write and one read in flight, byte-merge on commit.
  logic        m_en, m_have_aw, m_have_w, m_bvalid, m_rvalid;
  logic [1:0]  m_aw_idx;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb, m_pulse;
  logic [31:0] m_reg [4];
  logic        m_aw_fire, m_w_fire, m_ar_fire;

  logic        e_awready, e_wready, e_arready, e_aw_hs, e_w_hs, e_ar_hs, e_commit;
  logic [1:0]  e_idx;
  logic [31:0] e_data, e_new;
  logic [3:0]  e_strb;

  always_comb begin
    e_awready = m_en & ~m_have_aw & ~m_bvalid;
    e_wready  = m_en & ~m_have_w & ~m_bvalid;
    e_arready = m_en & ~m_rvalid;
    e_aw_hs   = awvalid & e_awready;
    e_w_hs    = wvalid & e_wready;
    e_ar_hs   = arvalid & e_arready;
    e_commit  = (m_have_aw | e_aw_hs) & (m_have_w | e_w_hs);
    e_idx     = e_aw_hs ? awaddr[3:2] : m_aw_idx;
    e_data    = e_w_hs ? wdata : m_wdata;
    e_strb    = e_w_hs ? wstrb : m_wstrb;
    e_new     = m_reg[e_idx];
    for (int k = 0; k < 4; k++) if (e_strb[k]) e_new[8*k +: 8] = e_data[8*k +: 8];
  end

  always @(posedge clk) begin
    if (!aresetn) begin
      m_en <= 1'b0; m_have_aw <= 1'b0; m_have_w <= 1'b0; m_bvalid <= 1'b0; m_rvalid <= 1'b0;
      m_aw_idx <= '0; m_wdata <= '0; m_wstrb <= '0; m_rdata <= '0; m_pulse <= '0;
      m_aw_fire <= 1'b0; m_w_fire <= 1'b0; m_ar_fire <= 1'b0;
      for (int i = 0; i < 4; i++) m_reg[i] <= '0;
    end else begin
      m_en <= 1'b1;
      m_aw_fire <= e_aw_hs; m_w_fire <= e_w_hs; m_ar_fire <= e_ar_hs;
      m_pulse <= '0;
      if (m_bvalid) begin
        if (bready) m_bvalid <= 1'b0;
      end else if (e_commit) begin
        m_reg[e_idx] <= e_new;
        m_pulse <= 4'b0001 << e_idx;
        m_bvalid <= 1'b1;
        m_have_aw <= 1'b0;
        m_have_w <= 1'b0;
      end else begin
        if (e_aw_hs) begin m_have_aw <= 1'b1; m_aw_idx <= awaddr[3:2]; end
        if (e_w_hs) begin m_have_w <= 1'b1; m_wdata <= wdata; m_wstrb <= wstrb; end
      end
      if (m_rvalid) begin
        if (rready) m_rvalid <= 1'b0;
      end else if (e_ar_hs) begin
        m_rvalid <= 1'b1;
        m_rdata <= m_reg[araddr[3:2]];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("awready", {31'd0, awready}, {31'd0, e_awready});
      chk("wready", {31'd0, wready}, {31'd0, e_wready});
      chk("bvalid", {31'd0, bvalid}, {31'd0, m_bvalid});
      chk("bresp", {30'd0, bresp}, 32'd0);
      chk("arready", {31'd0, arready}, {31'd0, e_arready});
      chk("rvalid", {31'd0, rvalid}, {31'd0, m_rvalid});
      chk("rdata", rdata, m_rdata);
      chk("rresp", {30'd0, rresp}, 32'd0);
      chk("reg0", reg0, m_reg[0]);
      chk("reg1", reg1, m_reg[1]);
      chk("reg2", reg2, m_reg[2]);
      chk("reg3", reg3, m_reg[3]);
      chk("reg_wr", {28'd0, reg_wr}, {28'd0, m_pulse});
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int da, input int dw, input int bhold);
    int n = 0;
    int h = 0;
    bit ad = 0;
    bit wd = 0;
    awaddr = a; wdata = d; wstrb = s; bready = (bhold == 0);
    while (!(ad && wd && !m_bvalid) && n < 100) begin
      @(negedge clk);
      if (m_aw_fire) begin ad = 1; awvalid = 1'b0; end
      if (m_w_fire) begin wd = 1; wvalid = 1'b0; end
      if (!ad && n >= da) awvalid = 1'b1;
      if (!wd && n >= dw) wvalid = 1'b1;
      if (m_bvalid) begin
        if (bhold > 0) chk("bp_bvalid_held", {31'd0, bvalid}, 32'd1);
        if (h >= bhold) bready = 1'b1;
        h++;
      end
      n++;
    end
    chk("wr_done", {31'd0, (ad && wd && !m_bvalid)}, 32'd1);
  endtask

  task automatic rd(input logic [3:0] a, input int hold, output logic [31:0] d);
    int n = 0;
    int h = 0;
    bit done = 0;
    bit seen = 0;
    logic [31:0] first;
    d = '0; first = '0;
    araddr = a; rready = (hold == 0);
    while (!(done && !m_rvalid) && n < 100) begin
      @(negedge clk);
      if (m_ar_fire) begin done = 1; arvalid = 1'b0; end
      else if (!done) arvalid = 1'b1;
      if (m_rvalid) begin
        if (!seen) begin first = rdata; seen = 1; end
        else chk("r_stable", rdata, first);
        d = rdata;
        if (h >= hold) rready = 1'b1;
        h++;
      end
      n++;
    end
    chk("rd_done", {31'd0, (done && !m_rvalid)}, 32'd1);
  endtask

  logic [31:0] v, v2;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_on = 0; total = 0; bad = 0;
    aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b1; rready = 1'b1;
    @(posedge clk);
    chk_on = 1;
    @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_reg3", reg3, 32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", {31'd0, awready}, 32'd1);

    for (int i = 0; i < 4; i++) wr(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    chk("model_reg3", m_reg[3], 32'd4);
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), 0, v);
      chk("seq_read", v, 32'(i + 1));
    end

    wr(4'h8, 32'h0, 4'hF, 0, 0, 0);
    wr(4'h8, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    chk("aw_lead_reg2", reg2, 32'hDEADBEEF);
    wr(4'h8, 32'h0, 4'hF, 0, 0, 0);
    wr(4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    chk("w_lead_reg2", reg2, 32'hDEADBEEF);

    wr(4'h4, 32'h11223344, 4'hF, 0, 0, 0);
    wr(4'h5, 32'hAABBCCDD, 4'b0101, 1, 0, 0);
    chk("strobe_reg1", reg1, 32'h11BB33DD);
    chk("model_strobe", m_reg[1], 32'h11BB33DD);
    wr(4'h6, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
    chk("zero_strobe_reg1", reg1, 32'h11BB33DD);

    wr(4'h0, 32'h00000077, 4'hF, 0, 0, 5);
    rd(4'h0, 5, v);
    chk("bp_read", v, 32'h77);

    wr(4'hC, 32'h5, 4'hF, 0, 0, 0);
    fork
      wr(4'hC, 32'h9, 4'hF, 0, 0, 0);
      rd(4'hC, 0, v);
    join
    chk("collide_old", v, 32'h5);
    rd(4'hF, 0, v2);
    chk("collide_new", v2, 32'h9);

    @(negedge clk);
    awaddr = 4'h4; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    for (int n = 0; n < 10 && wvalid; n++) begin
      @(negedge clk);
      if (m_w_fire) wvalid = 1'b0;
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("rst_mid_no_bvalid", {31'd0, bvalid}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), 0, v);
      chk("rst_mid_reg", v, 32'd0);
    end
    @(negedge clk); aresetn = 1'b0;
    @(negedge clk); aresetn = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (m_aw_fire) awvalid = 1'b0;
      if (m_w_fire) wvalid = 1'b0;
      if (m_ar_fire) arvalid = 1'b0;
      if (!awvalid && $urandom_range(3) == 0) begin awvalid = 1'b1; awaddr = 4'($urandom); end
      if (!wvalid && $urandom_range(3) == 0) begin
        wvalid = 1'b1; wdata = $urandom; wstrb = 4'($urandom);
      end
      if (!arvalid && $urandom_range(2) == 0) begin arvalid = 1'b1; araddr = 4'($urandom); end
      bready = 1'($urandom);
      rready = 1'($urandom);
      aresetn = ($urandom_range(399) != 0);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; aresetn = 1'b1; bready = 1'b1; rready = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
